if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage of the 5-stage RV32I pipeline, directly upstream of decode/control.
//  Owns the PC register and the next-PC selection, drives the instruction-memory address, and
//  registers {pc, pc+4, instr, valid} into the IF/ID pipeline register. Consumes control's
//  redirect (PCSel + target) and insert_nop_flag; squashes wrong-path fetches with NOP bubbles.
// PARAMETERS
//  XLEN          32            datapath / address width
//  RESET_PC      32'h0000_0000 PC value loaded on reset
//  FLUSH_CYCLES  2             bubbles issued per redirect (>=1; elaboration error otherwise)
// PORTS
//  clk            in   1     clock, rising edge
//  rst_n          in   1     reset, asynchronous, active-low
//  stall_i        in   1     hazard unit: hold PC and IF/ID contents
//  redirect_i     in   1     control PCSel: taken branch/JAL/JALR
//  redirect_pc_i  in   XLEN  redirect target (ALU result)
//  insert_nop_i   in   1     control insert_nop_flag: inject one bubble per asserted cycle
//  imem_addr_o    out  XLEN  instruction-memory address (= current PC)
//  imem_rdata_i   in   32    instruction word, combinational read of imem_addr_o
//  if_id_pc_o     out  XLEN  PC of registered instruction
//  if_id_pc4_o    out  XLEN  if_id_pc_o + 4 (for JAL/JALR writeback)
//  if_id_instr_o  out  32    registered instruction (NOP_INSTR when bubble)
//  if_id_valid_o  out  1     1 = real instruction, 0 = bubble
//  flush_o        out  1     1 while in FLUSH state
// BEHAVIOUR
//  Reset (async): pc=RESET_PC, if_id_pc_o=0, if_id_pc4_o=4, if_id_instr_o=NOP_INSTR,
//   if_id_valid_o=0, state=RUN, flush counter=0, flush_o=0. Reset mid-FLUSH aborts the flush.
//  imem_addr_o = pc, purely combinational; 1-cycle latency from PC to IF/ID outputs.
//  Per-cycle priority: redirect_i > stall_i > FLUSH > insert_nop_i > normal fetch.
//  RUN, normal: IF/ID <= {pc, pc+4, imem_rdata_i, 1}; pc <= pc+4.
//  redirect_i (any state, overrides stall_i): pc <= {redirect_pc_i[XLEN-1:1],1'b0};
//   IF/ID <= {0, 4, NOP_INSTR, 0}. FLUSH_CYCLES==1 -> stay RUN; else -> FLUSH with
//   cnt=FLUSH_CYCLES-1. Redirect while in FLUSH restarts cnt and replaces the target.
//  stall_i (no redirect): pc, IF/ID, state, cnt all hold.
//  FLUSH (no redirect/stall): pc holds; IF/ID <= bubble; cnt--; on cnt==1 -> RUN.
//   Total bubbles per redirect = FLUSH_CYCLES; target fetched on first RUN cycle after.
//  insert_nop_i in RUN (no redirect/stall): IF/ID <= bubble; pc holds (no instruction lost).
//  PC arithmetic modulo 2^XLEN: pc+4 at 32'hFFFF_FFFC wraps to 0. No misalign trap;
//   bit0 of target cleared (JALR rule); bit1 passed through unchanged.
//  flush_o = (state==FLUSH). Counter width $clog2(FLUSH_CYCLES+1).
// STRUCTURE
//  Shared package risc_v_pipeline_pkg: NOP_INSTR (32'h0000_0013), XLEN, fetch_state_t
//   enum {RUN, FLUSH}, if_id_t struct {pc, pc4, instr, valid}.
//  One sub-module: if_id_reg (IF/ID register with load/hold/bubble controls, async reset to
//   bubble); next-PC mux, FSM and counter stay in if_stage.
// TESTING
//  1 RESET_PC=0x100, imem returns addr^0xA5A5_0000; release reset -> imem_addr 0x100,0x104..;
//    next clk IF/ID={0x100,0x104,0xA5A5_0100,1}.
//  2 redirect_i at pc=0x10C, target 0x201 -> pc=0x200; 2 bubble cycles (valid=0,
//    instr=0x13, flush_o=1 on 2nd); 3rd cycle IF/ID pc=0x200 valid=1.
//  3 stall_i high 3 cycles at pc=0x110 -> imem_addr and all IF/ID outputs unchanged; resumes
//    with 0x110.
//  4 insert_nop_i 1 cycle at pc=0x120 -> one bubble, next valid IF/ID pc=0x120 (none skipped).
//  5 redirect_i+stall_i same cycle -> redirect taken; 2nd redirect to 0x300 mid-FLUSH ->
//    2 fresh bubbles, then 0x300.
//  6 pc=0xFFFF_FFFC normal fetch -> next pc 0x0; rst_n low mid-FLUSH -> flush_o=0,
//    valid=0, pc=RESET_PC immediately (async).

Source files
------------

// File: rtl/risc_v_pipeline_pkg.sv
// rtl/risc_v_pipeline_pkg.sv - shared pipeline types and constants for the RV32I core
package risc_v_pipeline_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [31:0]     instr;
    logic            valid;
  } if_id_t;

  // Contents of the IF/ID register when it carries no instruction
  localparam if_id_t IF_ID_BUBBLE = '{
    pc:    '0,
    pc4:   XLEN'(4),
    instr: NOP_INSTR,
    valid: 1'b0
  };

endpackage

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - control, instruction-memory and IF/ID signals of the fetch stage
interface if_stage_if #(
  parameter int XLEN = risc_v_pipeline_pkg::XLEN
);

  logic            stall_i;
  logic            redirect_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            insert_nop_i;
  logic [XLEN-1:0] imem_addr_o;
  logic [31:0]     imem_rdata_i;
  logic [XLEN-1:0] if_id_pc_o;
  logic [XLEN-1:0] if_id_pc4_o;
  logic [31:0]     if_id_instr_o;
  logic            if_id_valid_o;
  logic            flush_o;

  // The fetch stage itself
  modport master (
    input  stall_i, redirect_i, redirect_pc_i, insert_nop_i, imem_rdata_i,
    output imem_addr_o, if_id_pc_o, if_id_pc4_o, if_id_instr_o, if_id_valid_o, flush_o
  );

  // Surrounding pipeline: hazard unit, control, instruction memory, decode
  modport slave (
    output stall_i, redirect_i, redirect_pc_i, insert_nop_i, imem_rdata_i,
    input  imem_addr_o, if_id_pc_o, if_id_pc4_o, if_id_instr_o, if_id_valid_o, flush_o
  );

endinterface

// File: rtl/if_stage_if_id_reg.sv
// rtl/if_stage_if_id_reg.sv - IF/ID pipeline register with load, hold and bubble controls
module if_id_reg
  import risc_v_pipeline_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load_i,
  input  logic   bubble_i,
  input  if_id_t d_i,
  output if_id_t q_o
);

  if_id_t q_q;

  // Bubble wins over load; with neither asserted the register holds (stall)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= IF_ID_BUBBLE;
    end else if (bubble_i) begin
      q_q <= IF_ID_BUBBLE;
    end else if (load_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch: PC, next-PC select, redirect flush FSM, IF/ID register
module if_stage #(
  parameter int                                    XLEN         = risc_v_pipeline_pkg::XLEN,
  parameter logic [risc_v_pipeline_pkg::XLEN-1:0] RESET_PC     = '0,
  parameter int                                    FLUSH_CYCLES = 2
) (
  input logic        clk,
  input logic        rst_n,
  if_stage_if.master bus
);

  import risc_v_pipeline_pkg::*;

  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  // The redirect cycle itself is the first bubble, the counter covers the rest
  localparam logic [CW-1:0] CNT_INIT = CW'(FLUSH_CYCLES - 1);

  if (FLUSH_CYCLES < 1) begin : g_bad_flush_cycles
    $error("if_stage: FLUSH_CYCLES must be at least 1");
  end
  if (XLEN != risc_v_pipeline_pkg::XLEN) begin : g_bad_xlen
    $error("if_stage: XLEN must match risc_v_pipeline_pkg::XLEN");
  end

  fetch_state_t    state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4;
  logic            load;
  logic            bubble;
  if_id_t          if_id_d;
  if_id_t          if_id_q;

  assign pc_plus4 = pc_q + XLEN'(4);

  // PC, fetch state and flush counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next PC, next state and IF/ID control; priority redirect > stall > flush > nop > fetch
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    load    = 1'b0;
    bubble  = 1'b0;
    if (bus.redirect_i) begin
      // bit0 cleared as JALR requires; bit1 left alone, no misalignment trap here
      pc_d   = {bus.redirect_pc_i[XLEN-1:1], 1'b0};
      bubble = 1'b1;
      if (FLUSH_CYCLES == 1) begin
        state_d = RUN;
        cnt_d   = '0;
      end else begin
        state_d = FLUSH;
        cnt_d   = CNT_INIT;
      end
    end else if (bus.stall_i) begin
      // hold everything: PC, IF/ID, state and counter
    end else if (state_q == FLUSH) begin
      bubble = 1'b1;
      cnt_d  = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        state_d = RUN;
      end
    end else if (bus.insert_nop_i) begin
      // PC holds so the instruction at pc is fetched next cycle, not skipped
      bubble = 1'b1;
    end else begin
      load = 1'b1;
      pc_d = pc_plus4;
    end
  end

  assign if_id_d = '{
    pc:    pc_q,
    pc4:   pc_plus4,
    instr: bus.imem_rdata_i,
    valid: 1'b1
  };

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (load),
    .bubble_i (bubble),
    .d_i      (if_id_d),
    .q_o      (if_id_q)
  );

  assign bus.imem_addr_o   = pc_q;
  assign bus.if_id_pc_o    = if_id_q.pc;
  assign bus.if_id_pc4_o   = if_id_q.pc4;
  assign bus.if_id_instr_o = if_id_q.instr;
  assign bus.if_id_valid_o = if_id_q.valid;
  assign bus.flush_o       = (state_q == FLUSH);

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed table-driven bench for the instruction fetch stage
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] XMASK  = 32'hA5A5_0000;

  logic clk;
  logic rst_n;

  if_stage_if #(.XLEN(32)) bus ();

  if_stage #(
    .XLEN         (32),
    .RESET_PC     (RST_PC),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Instruction memory: word is its own address scrambled with a fixed mask
  assign bus.imem_rdata_i = bus.imem_addr_o ^ XMASK;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [31:0] target;
    logic        nop;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_pc4;
    logic [31:0] e_instr;
    logic        e_valid;
    logic        e_flush;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(logic st, logic rd, logic [31:0] tgt, logic nop,
                              logic [31:0] addr, logic [31:0] pc, logic v, logic f);
    vec_t r;
    r.stall    = st;
    r.redirect = rd;
    r.target   = tgt;
    r.nop      = nop;
    r.e_addr   = addr;
    r.e_valid  = v;
    r.e_flush  = f;
    if (v) begin
      r.e_pc    = pc;
      r.e_pc4   = pc + 32'd4;
      r.e_instr = pc ^ XMASK;
    end else begin
      r.e_pc    = 32'd0;
      r.e_pc4   = 32'd4;
      r.e_instr = NOP;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] addr, input logic [31:0] pc,
                         input logic [31:0] pc4, input logic [31:0] instr,
                         input logic v, input logic f);
    chk({tag, " imem_addr"}, bus.imem_addr_o, addr);
    chk({tag, " if_id_pc"}, bus.if_id_pc_o, pc);
    chk({tag, " if_id_pc4"}, bus.if_id_pc4_o, pc4);
    chk({tag, " if_id_instr"}, bus.if_id_instr_o, instr);
    chk({tag, " if_id_valid"}, {31'd0, bus.if_id_valid_o}, {31'd0, v});
    chk({tag, " flush"}, {31'd0, bus.flush_o}, {31'd0, f});
  endtask

  task automatic drive(input logic st, input logic rd, input logic [31:0] tgt, input logic nop);
    bus.stall_i       = st;
    bus.redirect_i    = rd;
    bus.redirect_pc_i = tgt;
    bus.insert_nop_i  = nop;
  endtask

  initial begin
    // sequential walk through fetch, redirect, stall, nop, double redirect, wrap
    vecs.push_back(mk(0, 0, 0, 0, 32'h104, 32'h100, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h108, 32'h104, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h10C, 32'h108, 1, 0));
    vecs.push_back(mk(0, 1, 32'h201, 0, 32'h200, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 32'h200, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h204, 32'h200, 1, 0));
    vecs.push_back(mk(0, 1, 32'h10C, 0, 32'h10C, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 32'h10C, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h110, 32'h10C, 1, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 0, 0, 0, 32'h110, 32'h10C, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h114, 32'h110, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h118, 32'h114, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h11C, 32'h118, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h120, 32'h11C, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h120, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h124, 32'h120, 1, 0));
    vecs.push_back(mk(1, 1, 32'h280, 0, 32'h280, 0, 0, 1));
    vecs.push_back(mk(0, 1, 32'h301, 0, 32'h300, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 32'h300, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h304, 32'h300, 1, 0));
    vecs.push_back(mk(0, 1, 32'h402, 0, 32'h402, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 32'h402, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 32'h402, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h406, 32'h402, 1, 0));
    vecs.push_back(mk(0, 1, 32'hFFFF_FFFD, 0, 32'hFFFF_FFFC, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 32'hFFFF_FFFC, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0, 32'hFFFF_FFFC, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h4, 32'h0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 32'h4, 32'h0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h4, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h8, 32'h4, 1, 0));

    rst_n = 1'b0;
    drive(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", RST_PC, 32'd0, 32'd4, NOP, 1'b0, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].stall, vecs[i].redirect, vecs[i].target, vecs[i].nop);
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_pc, vecs[i].e_pc4,
              vecs[i].e_instr, vecs[i].e_valid, vecs[i].e_flush);
    end

    // asynchronous reset in the middle of a flush
    drive(0, 1, 32'h500, 0);
    @(posedge clk);
    #1;
    chk_all("pre_rst", 32'h500, 32'd0, 32'd4, NOP, 1'b0, 1'b1);
    drive(0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", RST_PC, 32'd0, 32'd4, NOP, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("post_rst", 32'h104, 32'h100, 32'h104, 32'h100 ^ XMASK, 1'b1, 1'b0);

    // back-to-back insert_nop: two bubbles, no PC advance, nothing skipped
    drive(0, 0, 0, 1);
    @(posedge clk);
    #1;
    chk_all("nop1", 32'h104, 32'd0, 32'd4, NOP, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_all("nop2", 32'h104, 32'd0, 32'd4, NOP, 1'b0, 1'b0);
    drive(0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_all("nop_resume", 32'h108, 32'h104, 32'h108, 32'h104 ^ XMASK, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
